// File: rtl/rst_req_gen.sv
// rst_req_gen: reset-request initiator; drives a held active-low reset
// into a target and waits for the target's synchronized release status.
//
// Ports:
//   clk            control-domain clock
//   rst_n          async active-low reset (restarts the power-on sequence)
//   sw_rst_req     single-cycle software request, honoured only when idle
//   tgt_rst_ack_n  target reset status, async to clk (low = in reset)
//   rst_out_n      registered active-low reset to the target
//   busy           high whenever a sequence is in progress
//   done           one-cycle pulse when the target has left reset
//   timeout        one-cycle pulse when a wait gives up
//
// Build option: RST_REQ_GEN_TIMEOUT_EN adds a per-state wait limit of
// TIMEOUT_CYC cycles; without it timeout is tied low and waits are unbounded.

module rst_req_gen #(
    parameter int PULSE_CYC   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_rst_req,
    input  logic tgt_rst_ack_n,
    output logic rst_out_n,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PULSE_CYC - 1);

    if ((SYNC_STAGES < 2) || (PULSE_CYC < SYNC_STAGES + 1) ||
        (TIMEOUT_CYC < 1)) begin : g_bad_param
        $error("rst_req_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2,
        S_IDLE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_out_n_q;
    logic                   ack_s;
    logic                   pulse_met;
    logic                   wait_exp;

    assign ack_s     = sync_q[SYNC_STAGES-1];
    assign pulse_met = (cnt_q == CNT_MAX);

    // State register, pulse counter, ack synchronizer, reset output flop.
    // rst_out_n is loaded from the next-state decode so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ASSERT;
            cnt_q       <= '0;
            sync_q      <= '0;
            rst_out_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tgt_rst_ack_n};
            rst_out_n_q <= (state_d != S_ASSERT);
        end
    end

    // Next-state decode. cnt only runs in ASSERT; ASSERT is entered only
    // from IDLE or reset, where cnt is already zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_ASSERT: begin
                cnt_d = pulse_met ? cnt_q : cnt_q + 1'b1;
                if (pulse_met && !ack_s) begin
                    state_d = S_RELEASE;
                end else if (pulse_met && wait_exp) begin
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (ack_s) begin
                    state_d = S_DONE;
                end else if (wait_exp) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (sw_rst_req) begin
                    state_d = S_ASSERT;
                end
            end
            default: begin
                state_d = S_ASSERT;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign rst_out_n = rst_out_n_q;

`ifdef RST_REQ_GEN_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYC - 1);

    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          timeout_q;
    logic          to_fire;

    assign wait_exp = (wcnt_q == WAIT_MAX);

    // The only ways out of ASSERT/RELEASE straight to IDLE are expiries.
    assign to_fire = (state_d == S_IDLE) &&
                     ((state_q == S_ASSERT) || (state_q == S_RELEASE));

    // Wait counter clears on every state change and saturates, so in
    // ASSERT an expiry is only acted on once the pulse minimum is met.
    always_comb begin
        wcnt_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_ASSERT) || (state_q == S_RELEASE))) begin
            wcnt_d = wait_exp ? wcnt_q : wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            timeout_q <= to_fire;
        end
    end

    assign timeout = timeout_q;
`else
    assign wait_exp = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rst_req_gen.sv
// tb_rst_req_gen: table-driven and scoreboarded bench for rst_req_gen.
// A small target model echoes rst_out_n back as tgt_rst_ack_n.

module tb_rst_req_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sw_rst_req = 1'b0;
    logic tgt_rst_ack_n;
    logic rst_out_n;
    logic busy;
    logic done;
    logic timeout;

    always #5 clk = ~clk;

    rst_req_gen #(
        .PULSE_CYC  (16),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw_rst_req),
        .tgt_rst_ack_n(tgt_rst_ack_n),
        .rst_out_n    (rst_out_n),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    // Target model: ack = rst_out_n delayed ack_dly clocks, or forced.
    logic [7:0] hist = 8'hFF;
    logic [2:0] ack_dly = 3'd2;
    logic       force_en = 1'b0;
    logic       force_val = 1'b1;

    always @(posedge clk) hist <= {hist[6:0], rst_out_n};

    always_comb begin
        if (force_en) tgt_rst_ack_n = force_val;
        else if (ack_dly == 3'd0) tgt_rst_ack_n = rst_out_n;
        else tgt_rst_ack_n = hist[ack_dly - 3'd1];
    end

    typedef struct {
        int width;
        int lat;
    } exp_t;

    typedef struct {
        int dly;
        int width;
        int lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[4];

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int to_seen = 0;
    int low_cnt = 0;
    int lat_cnt = 0;
    int rel_w = 0;
    bit in_rel = 1'b0;
    logic prev_o = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures low width and release-to-done latency, pops the
    // scoreboard on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            low_cnt = 0;
            in_rel  = 1'b0;
            prev_o  = 1'b0;
        end else begin
            if (!rst_out_n) begin
                if (prev_o) low_cnt = 0;
                low_cnt++;
                in_rel = 1'b0;
            end else if (!prev_o) begin
                in_rel  = 1'b1;
                lat_cnt = 0;
                rel_w   = low_cnt;
            end else if (in_rel) begin
                lat_cnt++;
            end
            if (timeout) to_seen++;
            if (done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("low_width", rel_w, mon_e.width);
                    check("done_latency", lat_cnt, mon_e.lat);
                end
                in_rel = 1'b0;
            end
            prev_o = rst_out_n;
        end
    end

    task automatic send_req();
        @(posedge clk);
        #1 sw_rst_req = 1'b1;
        @(posedge clk);
        #1 sw_rst_req = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < max);
        if (!done) check(name, 0, 1);
    endtask

    task automatic wait_out(input logic lvl, input int max, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rst_out_n !== lvl && n < max);
        if (rst_out_n !== lvl) check(name, int'(rst_out_n), int'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int n;
        int d0;

        tbl[0] = '{0, 16, 3};
        tbl[1] = '{1, 16, 4};
        tbl[2] = '{2, 16, 5};
        tbl[3] = '{3, 16, 6};

        // Power-on: reset values, then automatic sequence.
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_out_n_in_reset", int'(rst_out_n), 0);
        check("busy_in_reset", int'(busy), 1);
        check("done_in_reset", int'(done), 0);
        check("timeout_in_reset", int'(timeout), 0);
        sb_q.push_back('{16, 5});
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(200, "poweron_done");
        @(negedge clk);
        check("poweron_busy_after", int'(busy), 0);

        // Software requests with the ack echoed at various delays.
        for (int i = 0; i < 4; i++) begin
            ack_dly = 3'(tbl[i].dly);
            repeat (5) @(posedge clk);
            sb_q.push_back('{tbl[i].width, tbl[i].lat});
            send_req();
            check("busy_on_accept", int'(busy), 1);
            wait_done(200, "vec_done");
            @(negedge clk);
            check("vec_busy_after", int'(busy), 0);
        end

        // Slow ack: target stays out of reset for 40 cycles.
        ack_dly   = 3'd0;
        force_val = 1'b1;
        force_en  = 1'b1;
        sb_q.push_back('{43, 3});
        send_req();
        wait_out(1'b0, 10, "slow_fall");
        repeat (40) @(posedge clk);
        #1 force_en = 1'b0;
        wait_done(200, "slow_done");

        // Requests during ASSERT, RELEASE and on the done cycle are dropped.
        repeat (5) @(posedge clk);
        d0 = n_done;
        sb_q.push_back('{16, 3});
        send_req();
        repeat (3) @(posedge clk);
        send_req();
        wait_out(1'b1, 100, "filt_rise");
        send_req();
        wait_done(50, "filt_done");
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1 sw_rst_req = 1'b0;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!rst_out_n) lows++;
        end
        check("filt_no_requeue", lows, 0);
        check("filt_one_done", n_done - d0, 1);
        check("filt_busy_after", int'(busy), 0);

        // Reset during RELEASE: async assert, no done, full restart.
        send_req();
        wait_out(1'b1, 100, "mid_rise");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_rst_out", int'(rst_out_n), 0);
        check("mid_busy", int'(busy), 1);
        sb_q.push_back('{16, 3});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(200, "mid_done");

        // Target stuck in reset.
        repeat (5) @(posedge clk);
        force_val = 1'b0;
        force_en  = 1'b1;
        d0 = n_done;
        send_req();
        wait_out(1'b1, 100, "stuck_rise");
`ifdef RST_REQ_GEN_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 200);
        check("to_latency", n, 64);
        check("to_rst_out_n", int'(rst_out_n), 1);
        check("to_busy", int'(busy), 0);
        @(negedge clk);
        check("to_one_cycle", int'(timeout), 0);
`else
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (!busy) n++;
        end
        check("stuck_not_idle", n, 0);
        check("stuck_busy", int'(busy), 1);
        check("stuck_rst_out_n", int'(rst_out_n), 1);
`endif
        check("stuck_no_done", n_done - d0, 0);

        // Recover through a power-on style reset.
        force_en = 1'b0;
        ack_dly  = 3'd2;
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.push_back('{16, 5});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(200, "recover_done");
        repeat (5) @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        check("total_done", n_done, 9);
`ifdef RST_REQ_GEN_TIMEOUT_EN
        check("timeout_count", to_seen, 1);
`else
        check("timeout_count", to_seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
